// File: rtl/execute_md_if.sv
// EX-stage bundle: ID/EX inputs, hazard/forwarding controls and
// EX/MEM register outputs of execute_md.
interface execute_md_if #(
    parameter int N    = 32,
    parameter int CW_W = 13
);
    logic            pipe_en;
    logic            flush;
    logic            valid_in;
    logic [CW_W-1:0] cwEX;
    logic [3:0]      aluOp;
    logic [2:0]      mdOp;
    logic [4:0]      Rdest_in;
    logic [N-1:0]    NPCin;
    logic [N-1:0]    NPC4_IN;
    logic [N-1:0]    r1;
    logic [N-1:0]    r2;
    logic [N-1:0]    Imm;
    logic [1:0]      forwardA;
    logic [1:0]      forwardB;
    logic [N-1:0]    aluRes_fwd;
    logic [N-1:0]    muxOut_fwd;
    logic [N-1:0]    jPC;
    logic            ex_stall;
    logic [N-1:0]    ALUres;
    logic [N-1:0]    wrData;
    logic [N-1:0]    ImmOUT;
    logic [N-1:0]    NPC4_OUT;
    logic [6:0]      cwMEM;
    logic [4:0]      Rdest;
    logic            PC_sel;
    logic            valid_out;

    modport master (
        output pipe_en, flush, valid_in, cwEX, aluOp, mdOp, Rdest_in,
               NPCin, NPC4_IN, r1, r2, Imm, forwardA, forwardB,
               aluRes_fwd, muxOut_fwd,
        input  jPC, ex_stall, ALUres, wrData, ImmOUT, NPC4_OUT,
               cwMEM, Rdest, PC_sel, valid_out
    );

    modport slave (
        input  pipe_en, flush, valid_in, cwEX, aluOp, mdOp, Rdest_in,
               NPCin, NPC4_IN, r1, r2, Imm, forwardA, forwardB,
               aluRes_fwd, muxOut_fwd,
        output jPC, ex_stall, ALUres, wrData, ImmOUT, NPC4_OUT,
               cwMEM, Rdest, PC_sel, valid_out
    );
endinterface

// File: rtl/execute_md.sv
// Execute stage with forwarding, branch resolution and EX/MEM register.
// Define EXE_MULDIV_EN to add the iterative RV32M multiply/divide unit.
module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];

    // Integer ALU: add/sub, shifts, compares, logic, pass-B
    always_comb begin
        y = '0;
        case (op)
            4'd0:    y = a + b;
            4'd1:    y = a - b;
            4'd2:    y = a << sh;
            4'd3:    y = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            4'd4:    y = {{(N-1){1'b0}}, a < b};
            4'd5:    y = a ^ b;
            4'd6:    y = a >> sh;
            4'd7:    y = $signed(a) >>> sh;
            4'd8:    y = a | b;
            4'd9:    y = a & b;
            4'd10:   y = b;
            default: y = '0;
        endcase
    end
endmodule

module execute_md #(
    parameter int N    = 32,
    parameter int CW_W = 13
) (
    input logic          clk,
    input logic          rst,
    execute_md_if.slave  bus
);
    logic [N-1:0] fa, fb, op_a, op_b, alu_y, ex_res;
    logic         taken, pc_sel_i, stall;

    // Forwarding muxes; code 11 falls back to the register file
    always_comb begin
        fa = bus.r1;
        fb = bus.r2;
        case (bus.forwardA)
            2'b01:   fa = bus.muxOut_fwd;
            2'b10:   fa = bus.aluRes_fwd;
            default: fa = bus.r1;
        endcase
        case (bus.forwardB)
            2'b01:   fb = bus.muxOut_fwd;
            2'b10:   fb = bus.aluRes_fwd;
            default: fb = bus.r2;
        endcase
    end

    assign op_a    = bus.cwEX[CW_W-1] ? fa : bus.NPCin;
    assign op_b    = bus.cwEX[CW_W-2] ? bus.Imm : fb;
    assign bus.jPC = bus.NPCin + (bus.Imm << 1);

    alu #(.N(N)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (bus.aluOp),
        .y  (alu_y)
    );

    // Branch condition evaluation on forwarded operands
    always_comb begin
        taken = 1'b0;
        case (bus.cwEX[CW_W-3 -: 3])
            3'b001:  taken = (fa == fb);
            3'b010:  taken = (fa != fb);
            3'b011:  taken = ($signed(fa) < $signed(fb));
            3'b100:  taken = ($signed(fa) >= $signed(fb));
            3'b101:  taken = (fa < fb);
            3'b110:  taken = (fa >= fb);
            default: taken = 1'b0;
        endcase
    end

    assign pc_sel_i = bus.valid_in & (taken | bus.cwEX[7]);

`ifdef EXE_MULDIV_EN
    localparam int SW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t      state;
    logic [2*N-1:0] acc, mul_next, div_next, prod;
    logic [N-1:0]   dvs, abs_a, abs_b, quo, rem, md_res, rem_sub;
    logic [N:0]     mul_sum, rem_sh;
    logic [SW:0]    cnt;
    logic [2:0]     op;
    logic           neg_q, neg_r, sgn_op, sgn_a, sgn_b;
    logic           md_start, div0, ovf, rem_ge;

    assign sgn_op   = (bus.mdOp == 3'b001) || (bus.mdOp == 3'b010) ||
                      (bus.mdOp == 3'b100) || (bus.mdOp == 3'b110);
    assign sgn_a    = sgn_op & fa[N-1];
    assign sgn_b    = sgn_op & fb[N-1];
    assign abs_a    = sgn_a ? -fa : fa;
    assign abs_b    = sgn_b ? -fb : fb;
    assign md_start = !rst && !bus.flush && bus.valid_in &&
                      (state == IDLE) && (bus.mdOp != 3'b000);
    assign div0     = bus.mdOp[2] && (fb == '0);
    assign ovf      = bus.mdOp[2] && !bus.mdOp[0] &&
                      (fa == MIN_NEG) && (fb == '1);

    // Shift-add multiply: product grows into the upper half
    assign mul_sum  = {1'b0, acc[2*N-1:N]} +
                      (acc[0] ? {1'b0, dvs} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, acc[N-1:1]};

    // Restoring divide: acc holds {remainder, dividend/quotient}
    assign rem_sh   = {acc[2*N-1:N], acc[N-1]};
    assign rem_ge   = rem_sh >= {1'b0, dvs};
    assign rem_sub  = rem_sh[N-1:0] - dvs;
    assign div_next = {rem_ge ? rem_sub : rem_sh[N-1:0],
                       acc[N-2:0], rem_ge};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[N-1:0] : acc[N-1:0];
    assign rem  = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];

    // Final result selection with sign correction
    always_comb begin
        md_res = '0;
        case (op)
            3'b001:         md_res = prod[N-1:0];
            3'b010:         md_res = prod[2*N-1:N];
            3'b011:         md_res = acc[2*N-1:N];
            3'b100, 3'b101: md_res = quo;
            3'b110, 3'b111: md_res = rem;
            default:        md_res = '0;
        endcase
    end

    assign stall  = md_start || (state == BUSY);
    assign ex_res = (state == DONE) ? md_res : alu_y;

    // MD sequencer; special divides preload acc so DONE needs no extra path
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            op    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        op    <= bus.mdOp;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        if (div0) begin
                            acc   <= {fa, {N{1'b1}}};
                            state <= DONE;
                        end else if (ovf) begin
                            acc   <= {{N{1'b0}}, fa};
                            state <= DONE;
                        end else begin
                            neg_q <= sgn_a ^ sgn_b;
                            neg_r <= sgn_a;
                            cnt   <= (SW+1)'(N);
                            state <= BUSY;
                            if (bus.mdOp[2]) begin
                                acc <= {{N{1'b0}}, abs_a};
                                dvs <= abs_b;
                            end else begin
                                acc <= {{N{1'b0}}, abs_b};
                                dvs <= abs_a;
                            end
                        end
                    end
                end
                BUSY: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == (SW+1)'(1)) state <= DONE;
                end
                DONE: begin
                    if (bus.pipe_en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign stall  = 1'b0;
    assign ex_res = alu_y;
`endif

    assign bus.ex_stall = stall;

    // EX/MEM register: bubble on reset, flush or stall; else load or hold
    always_ff @(posedge clk) begin
        if (rst || bus.flush || (bus.pipe_en && stall)) begin
            bus.ALUres    <= '0;
            bus.wrData    <= '0;
            bus.ImmOUT    <= '0;
            bus.NPC4_OUT  <= '0;
            bus.cwMEM     <= '0;
            bus.Rdest     <= '0;
            bus.PC_sel    <= 1'b0;
            bus.valid_out <= 1'b0;
        end else if (bus.pipe_en) begin
            bus.ALUres    <= ex_res;
            bus.wrData    <= fb;
            bus.ImmOUT    <= bus.Imm;
            bus.NPC4_OUT  <= bus.NPC4_IN;
            bus.cwMEM     <= bus.valid_in ? bus.cwEX[6:0] : 7'd0;
            bus.Rdest     <= bus.Rdest_in;
            bus.PC_sel    <= pc_sel_i;
            bus.valid_out <= bus.valid_in;
        end
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised successor of the 5-stage RISC-V-lite execute stage.
- Adds to the base stage: forwarding applied before operand selection, signed/unsigned branch resolution, and an iterative multiply/divide unit (RV32M semantics) that stalls upstream while busy.
- Adds valid tracking and flush to the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory stage; consumes the forwarding-unit and hazard-unit controls.

Parameters:
N 32 datapath width (even, >=8)
CW_W 13 execute control-word width; low 7 bits are the MEM control word

Ports:
clk in 1 clock
rst in 1 reset: synchronous, active-high
pipe_en in 1 EX/MEM register load enable from hazard unit
flush in 1 squash the instruction currently in EX (mispredict/exception)
valid_in in 1 instruction in EX is valid
cwEX in CW_W [12] selA, [11] selB, [10:8] branch cond, [7] jump, [6:0] cwMEM
aluOp in 4 ALU operation
mdOp in 3 000 none, 001 MUL, 010 MULH, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Rdest_in in 5 destination register
NPCin in N PC of instruction
NPC4_IN in N PC+4
r1, r2 in N register-file operands
Imm in N immediate
forwardA, forwardB in 2 00 regfile, 01 muxOut_fwd (WB), 10 aluRes_fwd (MEM), 11 treated as 00
aluRes_fwd, muxOut_fwd in N forwarded values
jPC out N branch/jump target (combinational)
ex_stall out 1 MD unit busy; upstream must hold
ALUres, wrData, ImmOUT, NPC4_OUT out N EX/MEM registered
cwMEM out 7 registered MEM control
Rdest out 5 registered destination
PC_sel out 1 registered redirect
valid_out out 1 registered valid

Behaviour:
- Forwarding: fa/fb = forward-muxed r1/r2. Branch compare, wrData and MD operands use fa/fb.
- ALU operand A = selA ? fa : NPCin. Operand B = selB ? Imm : fb.
- jPC = NPCin + (Imm << 1), truncated to N.
- Branch codes: 000 none, 001 BEQ, 010 BNE, 011 BLT (signed), 100 BGE (signed), 101 BLTU, 110 BGEU, 111 never taken.
- Redirect: pc_sel_i = valid_in & (taken | jump).
- MD FSM has three states: IDLE, BUSY, DONE.
  - IDLE: if valid_in & mdOp!=0 & !flush, latch |fa|, |fb|, sign info and op. Go to BUSY with counter=N; ex_stall=1 combinationally this cycle.
  - Divide by zero: skip BUSY, go straight to DONE. Quotient = all ones; remainder = fa.
  - Signed overflow (fa = -2^(N-1), fb = -1, DIV/REM): skip BUSY, go straight to DONE. Quotient = fa; remainder = 0.
  - BUSY: one radix-2 step per cycle (shift-add multiply into 2N product; restoring divide). Counter decrements; at 1, go to DONE. ex_stall=1.
  - DONE: apply sign correction; select low/high product, quotient or remainder; drive it instead of the ALU result. ex_stall=0.
  - DONE exits to IDLE when pipe_en=1; otherwise it holds the result.
- Latency: normal MD op stalls N+1 cycles. Special cases stall 1 cycle. Non-MD ops have 0 stall.
- EX/MEM register update:
  - rst: all outputs 0, FSM to IDLE. ex_stall=0.
  - flush (priority over pipe_en): load a bubble (valid_out=0, cwMEM=0, PC_sel=0, Rdest=0; data don't-care, implemented as 0). FSM aborts to IDLE.
  - pipe_en & ex_stall: load a bubble.
  - pipe_en & !ex_stall: load the live values. valid_out=valid_in. cwMEM=cwEX[6:0] if valid_in, else 0.
  - !pipe_en: hold.
- Inputs must stay stable while ex_stall=1. A change is not detected (verification asserts stability).
- ALU is the existing ALU block, instantiated with width N.

Optional Feature:
EXE_MULDIV_EN
- Defined: MD unit present as described.
- Undefined: mdOp is ignored; the instruction executes as a plain ALU op. ex_stall is tied 0, no FSM registers exist, and area matches the base stage.

Test Plan:
- forwardA=10, aluRes_fwd=5, r1=99, selA=1, selB=1, Imm=3, aluOp=ADD -> ALUres=8 after one edge; valid_out=1; ex_stall=0.
- BLT: fa=0xFFFFFFFF, fb=1, NPCin=0x100, Imm=8, branch=011 -> PC_sel=1, jPC=0x110. Same operands with BLTU (101) -> PC_sel=0.
- MUL: fa=7, fb=-3 (N=32) -> ex_stall high exactly 33 cycles, then ALUres=0xFFFFFFEB. MULHU on 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. Bubbles (valid_out=0) enter EX/MEM during the stall.
- DIV: fa=20, fb=0 -> 1-cycle stall, ALUres=0xFFFFFFFF. REM with same operands -> 20. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- DIVU started, flush asserted on 5th BUSY cycle -> next cycle FSM IDLE, ex_stall=0, valid_out=0, cwMEM=0.
- rst asserted mid-BUSY -> next edge all outputs 0, ex_stall=0. pipe_en=0 in DONE -> result held until pipe_en=1, then FSM goes to IDLE.
